// File: rtl/sram_if_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the byte-wide SRAM pin interface, used by the host
// controller and the SRAM tile so both sides agree on the pin packing.
package sram_if_pkg;

   localparam int SRAM_ADDR_WIDTH = 4;
   localparam int SRAM_DATA_WIDTH = 8;

   localparam int ADDR_LSB = 0;
   localparam int WE_BIT   = 4;
   localparam int OE_BIT   = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2
   } state_t;

   function automatic logic [7:0] pack_pins(input logic [SRAM_ADDR_WIDTH-1:0] addr,
                                            input logic we,
                                            input logic oe);
      logic [7:0] bus;
      bus = 8'h00;
      bus[ADDR_LSB +: SRAM_ADDR_WIDTH] = addr;
      bus[WE_BIT] = we;
      bus[OE_BIT] = oe;
      return bus;
   endfunction

endpackage

// File: rtl/sram_host_ctrl.sv
`timescale 1ns/1ps
// Host-side SRAM controller: takes read/write requests on a valid/ready port,
// drives the SRAM pins and returns read data on a one-cycle response strobe.
module sram_host_ctrl
   import sram_if_pkg::*;
#(
   parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
   parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
   parameter int RD_LAT     = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   output logic                  mem_oe,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [7:0]            mem_bus
);

   // The 3-bit wait counter has to reach RD_LAT without wrapping.
   generate
      if (RD_LAT < 1 || RD_LAT > 7) begin : g_bad_rd_lat
         $error("sram_host_ctrl: RD_LAT must lie within 1..7");
      end
   endgenerate

   localparam logic [2:0] LAST_CNT = 3'(RD_LAT);

   state_t     state;
   logic [2:0] count;

   assign req_ready = (state == IDLE) && rst_n;
   assign mem_bus   = pack_pins(SRAM_ADDR_WIDTH'(mem_addr), mem_we, mem_oe);

   // Read data is captured on the edge after the SRAM has had RD_LAT edges to
   // drive mem_rdata; the following IDLE cycle doubles as bus turnaround.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         count     <= 3'd0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_we    <= 1'b0;
         mem_oe    <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  mem_addr <= req_addr;
                  if (req_write) begin
                     mem_wdata <= req_wdata;
                     mem_we    <= 1'b1;
                     state     <= WR;
                  end else begin
                     mem_oe <= 1'b1;
                     count  <= 3'd0;
                     state  <= RD;
                  end
               end
            end
            WR: begin
               mem_we <= 1'b0;
               state  <= IDLE;
            end
            RD: begin
               if (count == LAST_CNT) begin
                  rsp_rdata <= mem_rdata;
                  rsp_valid <= 1'b1;
                  mem_oe    <= 1'b0;
                  state     <= IDLE;
               end else begin
                  count <= count + 3'd1;
               end
            end
            default: begin
               mem_we <= 1'b0;
               mem_oe <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule
